// File: rtl/cla32_pipe_if.sv
// Operand/result handshake bundle for cla32_pipe.
// The master modport is the producer/consumer side and the slave modport is the adder.
interface cla32_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/cla32_pipe.sv
// Two-stage pipelined adder built from 4-bit carry-lookahead slices.
// The low half is added in stage 1 and the high half in stage 2; valid/ready is used on both sides.
module cla32_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  cla32_pipe_if.slave  bus
);
  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned NS = H / 4;

  // One 4-bit lookahead slice. The result is packed as {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Ripple the carry through NS slices to cover one half-width.
  function automatic logic [H:0] ripple(input logic [H-1:0] x, input logic [H-1:0] y, input logic ci);
    logic [H-1:0] s;
    logic         carry;
    logic [4:0]   r;
    carry = ci;
    s     = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      r            = cla4(x[4*i +: 4], y[4*i +: 4], carry);
      s[4*i +: 4]  = r[3:0];
      carry        = r[4];
    end
    return {carry, s};
  endfunction

  logic         s1_valid;
  logic [H-1:0] s1_sum_lo;
  logic         s1_c_mid;
  logic [H-1:0] s1_a_hi;
  logic [H-1:0] s1_b_hi;
  logic         s2_valid;
  logic [WIDTH-1:0] sum_q;
  logic         c_out_q;
  logic         overflow_q;

  logic         s2_adv_c;
  logic         s1_adv_c;
  logic         accept_c;
  logic [H:0]   lo_c;
  logic [H:0]   hi_c;
  logic         a_msb_c;
  logic         b_msb_c;

  // Handshake: ready depends only on the valid flags and out_ready.
  always_comb begin
    s2_adv_c = !s2_valid || bus.out_ready;
    s1_adv_c = !s1_valid || s2_adv_c;
    accept_c = bus.in_valid && s1_adv_c;
  end

  // The top bits of the registered upper halves are the operand sign bits.
  always_comb begin
    lo_c    = ripple(bus.a[H-1:0], bus.b[H-1:0], bus.c_in);
    hi_c    = ripple(s1_a_hi, s1_b_hi, s1_c_mid);
    a_msb_c = s1_a_hi[H-1];
    b_msb_c = s1_b_hi[H-1];
  end

  // Stage 1: low-half add, capture mid-carry and upper operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sum_lo <= '0;
      s1_c_mid  <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
    end else if (s1_adv_c) begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_sum_lo <= lo_c[H-1:0];
        s1_c_mid  <= lo_c[H];
        s1_a_hi   <= bus.a[WIDTH-1:H];
        s1_b_hi   <= bus.b[WIDTH-1:H];
      end
    end
  end

  // Stage 2: high-half add from c_mid, register the full result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (s2_adv_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum_q      <= {hi_c[H-1:0], s1_sum_lo};
        c_out_q    <= hi_c[H];
        overflow_q <= (a_msb_c == b_msb_c) && (hi_c[H-1] != a_msb_c);
      end
    end
  end

  assign bus.in_ready  = s1_adv_c;
  assign bus.out_valid = s2_valid;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_cla32_pipe.sv
// Directed and streaming checks for cla32_pipe.
// A scoreboard queue holds {overflow, c_out, sum} in acceptance order.
module tb_cla32_pipe;
  localparam int unsigned WIDTH = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_rx;
  logic [33:0] exp_q[$];

  cla32_pipe_if #(.WIDTH(WIDTH)) bus ();

  cla32_pipe #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Golden result for random vectors: {overflow, c_out, sum}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    logic [32:0] full;
    logic        ovf;
    full = {1'b0, x} + {1'b0, y} + {32'b0, ci};
    ovf  = (x[31] == y[31]) && (full[31] != x[31]);
    return {ovf, full[32], full[31:0]};
  endfunction

  // Present one operand set and hold it until the bench sees in_ready high.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci,
                      input logic [33:0] e, output int waits);
    bit ok;
    waits = 0;
    ok    = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.a        = x;
    bus.b        = y;
    bus.c_in     = ci;
    while (!ok && waits < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        exp_q.push_back(e);
      end else begin
        waits++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) check("send_timeout", 64'(waits), 64'd0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: each result transfer must match the oldest outstanding operand.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 64'd1, 64'd0);
      end else begin
        check("result", {30'b0, bus.overflow, bus.c_out, bus.sum}, {30'b0, exp_q.pop_front()});
        n_rx++;
      end
    end
  end

  initial begin
    int w;
    int base;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    n_checks      = 0;
    n_fail        = 0;
    n_rx          = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held 3 cycles with in_valid toggling.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = ~bus.in_valid;
      bus.a        = 32'hDEAD_BEEF;
      bus.b        = 32'h1234_5678;
      @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_sum", 64'(bus.sum), 64'd0);
    end
    check("rst_c_out", 64'(bus.c_out), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_sum", 64'(bus.sum), 64'd0);

    // Single op through c_mid with exact 2-cycle latency.
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 32'h0001_0000}, w);
    check("single_ready", 64'(w), 64'd0);
    idle();
    @(negedge clk);
    check("lat_cycle1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2", 64'(bus.out_valid), 64'd1);
    wait_drain("drain_single");

    // Carry and overflow boundaries, back to back.
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b0, 1'b1, 32'h0000_0000}, w);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 32'h8000_0000}, w);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 1'b1, 32'h0000_0000}, w);
    send(32'h1234_5678, 32'h1111_1111, 1'b1, {1'b0, 1'b0, 32'h2345_678A}, w);
    idle();
    wait_drain("drain_boundary");

    // 100 back-to-back random ops: in_ready never drops, one result per cycle.
    base = n_rx;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc), w);
      check("stream_ready", 64'(w), 64'd0);
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    check("stream_count", 64'(n_rx - base), 64'd100);
    wait_drain("drain_stream");

    // Backpressure: out_ready low for 5 cycles with in_valid high.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.c_in = 1'b0;
      end else if (i == 1) begin
        bus.a = 32'hF000_0000; bus.b = 32'h2000_0000; bus.c_in = 1'b1;
      end else begin
        bus.a = 32'h0000_0005; bus.b = 32'h0000_0003; bus.c_in = 1'b0;
      end
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), (i < 2) ? 64'd1 : 64'd0);
      if (i == 0) exp_q.push_back({1'b0, 1'b0, 32'h2345_6789});
      if (i == 1) exp_q.push_back({1'b0, 1'b1, 32'h1000_0001});
      if (i >= 2) begin
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_sum_stable", 64'(bus.sum), 64'h2345_6789);
        check("bp_c_out_stable", 64'(bus.c_out), 64'd0);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    base          = n_rx;
    wait_drain("drain_bp");
    check("bp_count", 64'(n_rx - base), 64'd2);

    // Reset with both stages full discards everything in flight.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, {1'b0, 1'b0, 32'h0000_0003}, w);
    send(32'h0000_0010, 32'h0000_0020, 1'b0, {1'b0, 1'b0, 32'h0000_0030}, w);
    idle();
    @(negedge clk);
    check("mid_full_out_valid", 64'(bus.out_valid), 64'd1);
    check("mid_full_in_ready", 64'(bus.in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_async_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_sum", 64'(bus.sum), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_result", 64'(bus.out_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
